rr_burst_arbiter: RTL and testbench

RR_BURST_ARBITER -- requirements
Module: rr_burst_arbiter

---
 rtl/arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 32 +++
 rtl/rr_burst_arbiter.sv | 113 +++++++++++
 tb/tb_rr_burst_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin burst arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int DEFAULT_N        = 8;
  localparam int DEFAULT_MAX_HOLD = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr, ascending modulo N.
module rr_pick #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] winner,
  output logic [W-1:0] index,
  output logic         any
);

  int j;

  // Walk offsets from farthest to nearest so the nearest eligible index wins.
  always_comb begin
    winner = '0;
    index  = '0;
    any    = 1'b0;
    j      = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (eligible[j]) begin
        winner    = '0;
        winner[j] = 1'b1;
        index     = W'(j);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter granting whole bursts; the owner keeps the grant while its req stays high.
// Define RR_ARB_TIMEOUT_EN to bound tenure at MAX_HOLD cycles and mask the revoked requester.
module rr_burst_arbiter
  import arb_pkg::*;
#(
  parameter int N        = DEFAULT_N,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 valid_grant,
  output logic                 timeout
);

  localparam int W = $clog2(N);

  arb_state_t     state;
  logic [W-1:0]   ptr;
  logic           armed;
  logic [N-1:0]   eligible;
  logic [N-1:0]   pick_winner;
  logic [W-1:0]   pick_index;
  logic           pick_any;
  logic [W-1:0]   next_ptr;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0]  hold_cnt;
  logic [N-1:0]   mask;

  assign eligible = req & ~mask;
`else
  assign eligible = req;
`endif

  assign next_ptr = (grant_id == W'(N - 1)) ? '0 : grant_id + W'(1);

  rr_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .winner   (pick_winner),
    .index    (pick_index),
    .any      (pick_any)
  );

  // armed holds off the first grant until one full cycle after reset release.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      grant_id    <= '0;
      valid_grant <= 1'b0;
      timeout     <= 1'b0;
      ptr         <= '0;
      armed       <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt    <= '0;
      mask        <= '0;
`endif
    end else begin
      armed   <= 1'b1;
      timeout <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      mask    <= mask & req;
`endif
      case (state)
        IDLE: begin
          if (armed && pick_any) begin
            state       <= BUSY;
            grant       <= pick_winner;
            grant_id    <= pick_index;
            valid_grant <= 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt    <= HW'(1);
`endif
          end
        end
        BUSY: begin
          if (!req[grant_id]) begin
            state       <= IDLE;
            grant       <= '0;
            grant_id    <= '0;
            valid_grant <= 1'b0;
            ptr         <= next_ptr;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt    <= '0;
          end else if (hold_cnt == HW'(MAX_HOLD)) begin
            // Revoke a requester that is still holding on; it stays masked until it lets go.
            state       <= IDLE;
            grant       <= '0;
            grant_id    <= '0;
            valid_grant <= 1'b0;
            ptr         <= next_ptr;
            timeout     <= 1'b1;
            hold_cnt    <= '0;
            mask        <= (mask & req) | grant;
          end else begin
            hold_cnt    <= hold_cnt + HW'(1);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed self-checking bench for rr_burst_arbiter with N = 4, MAX_HOLD = 4.
module tb_rr_burst_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [1:0]   grant_id;
  logic         valid_grant;
  logic         timeout;

  int vectors;
  int miscompares;

  rr_burst_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .grant_id    (grant_id),
    .valid_grant (valid_grant),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      $display("vec %0d %s obs=%0h exp=%0h ok", vectors, tag, obs, exp);
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full observable state: grant, grant_id, valid_grant, timeout.
  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                            input logic tmo);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".grant_id"}, 32'(grant_id), 32'(id));
    check({tag, ".valid"}, 32'(valid_grant), 32'(g != 4'b0000));
    check({tag, ".timeout"}, 32'(timeout), 32'(tmo));
  endtask

  initial begin
    logic [3:0] onehot;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    req         = 4'b0000;
    step();
    step();
    expect_out("reset", 4'b0000, 2'd0, 1'b0);

    // Basic burst handoff: 0 then 2 with one idle cycle between.
    reset = 1'b0;
    step();
    req = 4'b0101;
    step();
    expect_out("first_grant", 4'b0001, 2'd0, 1'b0);
    step();
    expect_out("hold0", 4'b0001, 2'd0, 1'b0);
    req = 4'b0100;
    step();
    expect_out("release0_idle", 4'b0000, 2'd0, 1'b0);
    step();
    expect_out("grant2", 4'b0100, 2'd2, 1'b0);
    req = 4'b0000;
    step();
    expect_out("release2", 4'b0000, 2'd0, 1'b0);

    // Rotation with all requesters active: 0,1,2,3,0.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      onehot = 4'b0001 << (k % 4);
      expect_out($sformatf("rot%0d_g", k), onehot, 2'(k % 4), 1'b0);
      step();
      step();
      expect_out($sformatf("rot%0d_held", k), onehot, 2'(k % 4), 1'b0);
      if (k < 4) begin
        req = 4'b1111 & ~onehot;
        step();
        expect_out($sformatf("rot%0d_rel", k), 4'b0000, 2'd0, 1'b0);
        req = 4'b1111;
        step();
      end
    end

    // Owner 0 releases; only requester 3 remains.
    req = 4'b1000;
    step();
    expect_out("rel_to3", 4'b0000, 2'd0, 1'b0);
    step();
    expect_out("grant3", 4'b1000, 2'd3, 1'b0);
    // Owner 3 releases while requester 0 rises: pointer wraps to 0.
    req = 4'b0001;
    step();
    expect_out("rel3_idle", 4'b0000, 2'd0, 1'b0);
    step();
    expect_out("wrap_grant0", 4'b0001, 2'd0, 1'b0);

    // Reset during a grant to requester 1.
    req = 4'b0010;
    step();
    step();
    expect_out("grant1", 4'b0010, 2'd1, 1'b0);
    reset = 1'b1;
    step();
    expect_out("reset_busy", 4'b0000, 2'd0, 1'b0);
    reset = 1'b0;
    req   = 4'b1111;
    step();
    expect_out("post_reset_gap", 4'b0000, 2'd0, 1'b0);
    step();
    expect_out("post_reset_g0", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000;
    step();
    expect_out("post_reset_rel", 4'b0000, 2'd0, 1'b0);

`ifdef RR_ARB_TIMEOUT_EN
    // Tenure limit: requester 1 is revoked after MAX_HOLD cycles and masked.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    req = 4'b0110;
    step();
    expect_out("to_g1", 4'b0010, 2'd1, 1'b0);
    for (int k = 0; k < MAX_HOLD - 1; k++) begin
      step();
      expect_out($sformatf("to_hold%0d", k), 4'b0010, 2'd1, 1'b0);
    end
    step();
    expect_out("to_revoke1", 4'b0000, 2'd0, 1'b1);
    step();
    expect_out("to_g2", 4'b0100, 2'd2, 1'b0);
    for (int k = 0; k < MAX_HOLD - 1; k++) step();
    step();
    expect_out("to_revoke2", 4'b0000, 2'd0, 1'b1);
    step();
    expect_out("to_masked_a", 4'b0000, 2'd0, 1'b0);
    step();
    expect_out("to_masked_b", 4'b0000, 2'd0, 1'b0);
    req = 4'b0000;
    step();
    req = 4'b0010;
    step();
    expect_out("to_unmasked", 4'b0010, 2'd1, 1'b0);
`else
    // Unbounded tenure: no revocation well past MAX_HOLD cycles.
    req = 4'b0100;
    step();
    expect_out("long_g2", 4'b0100, 2'd2, 1'b0);
    for (int k = 0; k < 3 * MAX_HOLD; k++) step();
    expect_out("long_hold", 4'b0100, 2'd2, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
